// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: MMIO pushes fill a circular buffer,
// a three-state drain FSM hands one byte at a time to the transmitter.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_clr_ovf,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_ovf,
  output logic          o_tx_rdy,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, ovf_q, ovf_d;
  logic          tx_rdy_q;
  logic [7:0]    tx_data_q;
  state_t        state_q;

  logic push, pop, ovf_set;

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push    = i_wr_en && !full_q;
  assign ovf_set = i_wr_en && full_q;
  assign pop     = (state_q == IDLE) && !empty_q && !i_tx_busy;

  always_comb begin
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_d   = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  // Drain FSM: launch a byte, wait for the transmitter to go busy, then idle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_rdy_q  <= 1'b1;
            tx_data_q <= mem[rd_ptr_q];
            state_q   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_full    = full_q;
  assign o_empty   = empty_q;
  assign o_count   = count_q;
  assign o_ovf     = ovf_q;
  assign o_tx_rdy  = tx_rdy_q;
  assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted pushes queue expected bytes,
// a negedge monitor pops and compares on every o_tx_rdy pulse.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          full, empty, ovf, tx_rdy, tx_busy;
  logic [AW:0]   count;
  logic [7:0]    tx_data;

  int            total = 0;
  int            bad = 0;
  int            rdy_cnt = 0;
  int            r0;
  int            n;
  logic [7:0]    exp_q [$];
  bit            hold_busy = 1'b0;
  int            busy_cnt = 0;
  logic          prev_rdy = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_clr_ovf (clr_ovf),
    .o_full    (full),
    .o_empty   (empty),
    .o_count   (count),
    .o_ovf     (ovf),
    .o_tx_rdy  (tx_rdy),
    .o_tx_data (tx_data),
    .i_tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from the cycle after o_tx_rdy for 10 bit-times.
  assign tx_busy = hold_busy || (busy_cnt != 0);
  always @(posedge clk or negedge rst) begin
    if (!rst) busy_cnt <= 0;
    else if (tx_rdy) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst && tx_rdy) begin
      rdy_cnt++;
      chk("rdy_pulse_width", {31'd0, prev_rdy}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got 0x%02h expected none", tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, e});
        $display("tx byte 0x%02h (expected 0x%02h)", tx_data, e);
      end
    end
    prev_rdy = tx_rdy;
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || tx_busy) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_tx_rdy", 32'(tx_rdy), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b1;
    tick(2);

    // Single byte round trip
    r0 = rdy_cnt;
    push(8'h55, 1'b1);
    drain(200);
    chk("single_rdy_cnt", 32'(rdy_cnt - r0), 32'd1);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_count", 32'(count), 32'd0);

    // Fill: first byte drains, then the transmitter is held busy
    r0 = rdy_cnt;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i), 1'b1);
      if (i == 3) hold_busy = 1'b1;
    end
    chk("fill_count15", 32'(count), 32'd15);
    chk("fill_not_full", 32'(full), 32'd0);
    push(8'h11, 1'b1);
    chk("fill_count16", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_not_empty", 32'(empty), 32'd0);
    chk("fill_one_drained", 32'(rdy_cnt - r0), 32'd1);

    // Overflow and sticky flag behaviour
    push(8'hAA, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count_kept", 32'(count), 32'd16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    clr_ovf = 1'b1;
    push(8'hBB, 1'b0);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared2", 32'(ovf), 32'd0);

    // Push in the same cycle as a pop with count = DEPTH-1
    hold_busy = 1'b0;
    n = 0;
    while (count !== 5'd15 && n < 100) begin tick(); n++; end
    chk("wrap_count15", 32'(count), 32'd15);
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin tick(); n++; end
    chk("wrap_busy_hi", 32'(tx_busy), 32'd1);
    n = 0;
    while (tx_busy !== 1'b0 && n < 100) begin tick(); n++; end
    chk("wrap_busy_lo", 32'(tx_busy), 32'd0);
    tick();
    push(8'hC0, 1'b1);
    chk("wrap_pop_same_cycle", 32'(tx_rdy), 32'd1);
    chk("wrap_count_same", 32'(count), 32'd15);
    drain(1000);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset while in WAIT_DONE with five bytes queued
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i), 1'b1);
    hold_busy = 1'b1;
    chk("mid_count5", 32'(count), 32'd5);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_tx_rdy", 32'(tx_rdy), 32'd0);
    exp_q.delete();
    hold_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    r0 = rdy_cnt;
    tick(30);
    chk("post_rst_no_rdy", 32'(rdy_cnt - r0), 32'd0);
    push(8'h77, 1'b1);
    drain(200);
    chk("post_rst_one_rdy", 32'(rdy_cnt - r0), 32'd1);

    // Busy held high blocks draining
    hold_busy = 1'b1;
    r0 = rdy_cnt;
    push(8'h81, 1'b1);
    push(8'h82, 1'b1);
    tick(20);
    chk("busy_blocks_rdy", 32'(rdy_cnt - r0), 32'd0);
    chk("busy_count2", 32'(count), 32'd2);
    hold_busy = 1'b0;
    drain(200);
    chk("busy_release_rdy", 32'(rdy_cnt - r0), 32'd2);
    chk("busy_release_empty", 32'(empty), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
